nms_window_buf: RTL
===================

// Module: nms_window_buf
// PURPOSE
//  Parametrised WINxWIN sliding-window generator for the NMS stage of the FAST pipeline.
//  Takes a raster stream of score words (one per accepted cycle), buffers WIN-1 lines, emits a full window.
//  Adds frame sync/wrap, per-pixel valid, end-of-frame and optional centre coordinates.
//  Sits between the FAST score stage and the NMS comparator.
// PARAMETERS
//  DATA_W   34   width of one pixel/score word
//  COL_NUM  640  pixels per line (>= WIN)
//  ROW_NUM  480  lines per frame (>= WIN)
//  WIN      3    window size; odd, 3..9; H = (WIN-1)/2
// PORTS
//  clk      in   1                 clock
//  rst      in   1                 synchronous reset, active-low
//  ce       in   1                 input valid/accept; one pixel consumed per cycle with ce=1
//  sof      in   1                 start of frame; qualified by ce; marks pixel (0,0)
//  data_in  in   DATA_W            pixel word
//  win      out  WIN*WIN*DATA_W    tap (i,j) at [(i*WIN+j)*DATA_W +: DATA_W]; i=0 oldest row, j=0 oldest col
//  win_vld  out  1                 one-cycle pulse: win holds a complete in-frame window
//  eof      out  1                 one-cycle pulse with the update for pixel (ROW_NUM-1,COL_NUM-1)
//  ctr_row  out  clog2(ROW_NUM)    centre row of win (NMS_WIN_COORD_EN only)
//  ctr_col  out  clog2(COL_NUM)    centre col of win (NMS_WIN_COORD_EN only)
// BEHAVIOUR
//  - Reset (rst=0 at posedge): row/col counters=0, win=0, win_vld=0, eof=0, ctr_row/ctr_col=0.
//    Line-buffer RAM is not cleared; stale content is masked by win_vld.
//  - Counters: col increments per accepted pixel, wraps COL_NUM-1 -> 0 and increments row.
//    Row wraps ROW_NUM-1 -> 0 without sof. Accepted sof forces the current pixel to (0,0).
//    Next pixel is (0,1). Counters restart regardless of position, including mid-line or mid-frame.
//  - Line buffers: WIN-1 RAMs of depth COL_NUM. Line k delays its input by exactly COL_NUM accepted pixels.
//    Line 0 input is data_in; line k input is line k-1 output. Same-address read-before-write.
//  - Latency 1: after accepting pixel (r,c), on the next edge tap (i,j) = pixel (r-WIN+1+i, c-WIN+1+j).
//  - win_vld=1 on that same edge iff r>=WIN-1 and c>=WIN-1. No window straddles a line or frame edge.
//    Per frame: (ROW_NUM-WIN+1)*(COL_NUM-WIN+1) pulses.
//  - ce=0: counters, RAMs, win hold; win_vld and eof drop to 0 next edge. sof ignored when ce=0.
//  - sof after an in-frame pixel: prior rows still sit in the RAMs but win_vld stays low until r>=WIN-1 in the new frame.
//  - sof on pixel (ROW_NUM-1,COL_NUM-1): sof wins; eof not raised.
//  - Counter width uses clog2; no overflow paths. Elaboration error if WIN even, <3, >9, or > COL_NUM/ROW_NUM.
// CONFIGURATION
//  NMS_WIN_COORD_EN defined:
//    ctr_row = r-H, ctr_col = c-H, registered with win, valid when win_vld=1, held otherwise.
//  NMS_WIN_COORD_EN undefined:
//    ctr_row/ctr_col ports absent; no coordinate logic.
//    Counters still exist for win_vld/eof.
// TESTING (COL_NUM=8, ROW_NUM=6, WIN=3 unless noted; data_in = {r,c} as r*16+c)
//  1. rst=0 for 3 cycles with ce=1, random data -> win=0, win_vld=0, eof=0 throughout.
//  2. sof at (0,0), full frame continuous ce:
//     first win_vld 1 cycle after (2,2), centre tap (1,1)=0x11, tap(0,0)=0x00;
//     24 pulses total; last centre 0x46; eof with last update.
//  3. Same frame with random ce gaps (~40% idle) -> window sequence identical to test 2;
//     win_vld/eof never high on the cycle after ce=0.
//  4. sof injected at (3,4) -> no win_vld until new-frame (2,2); then centre=0x11 from new data only.
//  5. Two frames back-to-back, no second sof -> eof once per frame;
//     frame-2 first vld after its (2,2); 48 pulses total.
//  6. WIN=5, COL_NUM=8, ROW_NUM=6 -> first vld after (4,4), centre (2,2)=0x22, 8 pulses;
//     with NMS_WIN_COORD_EN: first ctr_row=2, ctr_col=2.

Source files
------------

// File: rtl/nms_window_buf_if.sv
// nms_window_buf_if: pixel stream in, window out, for nms_window_buf.
// master = score source / NMS consumer side, slave = window buffer.
// ctr_row/ctr_col exist only when NMS_WIN_COORD_EN is defined.
interface nms_window_buf_if #(
  parameter int DATA_W  = 34,
  parameter int COL_NUM = 640,
  parameter int ROW_NUM = 480,
  parameter int WIN     = 3
) ();
  logic                       ce;
  logic                       sof;
  logic [DATA_W-1:0]          data_in;
  logic [WIN*WIN*DATA_W-1:0]  win;
  logic                       win_vld;
  logic                       eof;
`ifdef NMS_WIN_COORD_EN
  logic [$clog2(ROW_NUM)-1:0] ctr_row;
  logic [$clog2(COL_NUM)-1:0] ctr_col;

  modport master (output ce, sof, data_in, input win, win_vld, eof, ctr_row, ctr_col);
  modport slave  (input ce, sof, data_in, output win, win_vld, eof, ctr_row, ctr_col);
`else
  modport master (output ce, sof, data_in, input win, win_vld, eof);
  modport slave  (input ce, sof, data_in, output win, win_vld, eof);
`endif
endinterface

// File: rtl/nms_window_buf.sv
// nms_window_buf: WINxWIN sliding window over a raster score stream for NMS.
// WIN-1 line RAMs delay the stream by whole lines; a WINxWIN register array
// shifts one column per accepted pixel. win_vld marks in-frame windows only.
// Optional feature macro: NMS_WIN_COORD_EN adds registered centre coordinates.

// One line delay: async read at the shared pointer, write at the same address
// on the clock edge, giving read-before-write and a delay of DEPTH accepts.
module nms_win_line #(
  parameter int DATA_W = 34,
  parameter int DEPTH  = 640,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign q_o = mem_q[addr_i];

  // storage is never cleared; stale words are masked downstream by win_vld
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= d_i;
  end
endmodule

module nms_window_buf #(
  parameter int DATA_W  = 34,
  parameter int COL_NUM = 640,
  parameter int ROW_NUM = 480,
  parameter int WIN     = 3
) (
  input logic             clk,
  input logic             rst,
  nms_window_buf_if.slave bus
);
  localparam int ROW_W = $clog2(ROW_NUM);
  localparam int COL_W = $clog2(COL_NUM);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_NUM - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_NUM - 1);
  localparam logic [ROW_W-1:0] ROW_VLD0 = ROW_W'(WIN - 1);
  localparam logic [COL_W-1:0] COL_VLD0 = COL_W'(WIN - 1);

  if ((WIN % 2) == 0 || WIN < 3 || WIN > 9 || WIN > COL_NUM || WIN > ROW_NUM) begin : g_bad_win
    $error("nms_window_buf: WIN must be odd, 3..9, and <= COL_NUM/ROW_NUM");
  end

  logic                                   acc;
  logic [ROW_W-1:0]                       row_q, row_d, cur_row;
  logic [COL_W-1:0]                       col_q, col_d, cur_col;
  // line pointer is independent of sof so every line delays exactly COL_NUM accepts
  logic [COL_W-1:0]                       ptr_q, ptr_d;
  logic                                   in_win;
  logic [DATA_W-1:0]                      line_d [WIN-1];
  logic [DATA_W-1:0]                      line_q [WIN-1];
  logic [WIN-1:0][DATA_W-1:0]             row_in;
  logic [WIN-1:0][WIN-1:0][DATA_W-1:0]    win_q, win_d;
  logic                                   win_vld_q, win_vld_d;
  logic                                   eof_q, eof_d;

  assign acc = bus.ce;

  // position of the pixel being accepted and the counters for the next one
  always_comb begin
    cur_row = bus.sof ? '0 : row_q;
    cur_col = bus.sof ? '0 : col_q;
    row_d   = row_q;
    col_d   = col_q;
    ptr_d   = ptr_q;
    if (acc) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
      ptr_d = (ptr_q == COL_LAST) ? '0 : ptr_q + COL_W'(1);
    end
    in_win    = (cur_row >= ROW_VLD0) && (cur_col >= COL_VLD0);
    win_vld_d = acc && in_win;
    eof_d     = acc && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  end

  // line k is fed by line k-1, line 0 by the input stream
  for (genvar k = 0; k < WIN - 1; k++) begin : g_line
    if (k == 0) begin : g_first
      assign line_d[k] = bus.data_in;
    end else begin : g_chain
      assign line_d[k] = line_q[k-1];
    end
    nms_win_line #(.DATA_W(DATA_W), .DEPTH(COL_NUM), .AW(COL_W)) u_line (
      .clk    (clk),
      .we_i   (acc),
      .addr_i (ptr_q),
      .d_i    (line_d[k]),
      .q_o    (line_q[k])
    );
  end

  // newest column of the window: row WIN-1 is live data, row i is WIN-1-i lines back
  always_comb begin
    row_in[WIN-1] = bus.data_in;
    for (int i = 0; i < WIN - 1; i++) row_in[i] = line_q[WIN-2-i];
  end

  // shift the window left by one column on every accepted pixel
  always_comb begin
    win_d = win_q;
    if (acc) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN - 1; j++) win_d[i][j] = win_q[i][j+1];
        win_d[i][WIN-1] = row_in[i];
      end
    end
  end

  // counters, window and status pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q     <= '0;
      col_q     <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
      win_vld_q <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      win_vld_q <= win_vld_d;
      eof_q     <= eof_d;
    end
  end

  assign bus.win     = win_q;
  assign bus.win_vld = win_vld_q;
  assign bus.eof     = eof_q;

`ifdef NMS_WIN_COORD_EN
  localparam int H = (WIN - 1) / 2;
  logic [ROW_W-1:0] ctr_row_q;
  logic [COL_W-1:0] ctr_col_q;

  // centre coordinate follows each valid window and holds otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctr_row_q <= '0;
      ctr_col_q <= '0;
    end else if (win_vld_d) begin
      ctr_row_q <= cur_row - ROW_W'(H);
      ctr_col_q <= cur_col - COL_W'(H);
    end
  end

  assign bus.ctr_row = ctr_row_q;
  assign bus.ctr_col = ctr_col_q;
`endif
endmodule
